// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and holds the IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_id,
  input  logic             branch,
  input  logic [31:0]      branch_addr,
  input  logic [31:0]      inst_rom_data_i,
  output logic [31:0]      inst_rom_addr_o,
  output logic             inst_rom_ce_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic             last_branch_o,
  input  logic             perf_clr_i,
  output logic [CNT_W-1:0] perf_fetch_o,
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_flush_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        lb_q, lb_d;
  logic        run;
  logic        acc_br;
  logic        unused_ba;

  assign run       = (state_q == S_RUN);
  assign acc_br    = run & branch & ~stall_id;
  // Targets are word aligned; the low address bits are dropped.
  assign unused_ba = ^branch_addr[1:0];

  always_comb begin
    state_d   = S_RUN;
    pc_d      = pc_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    lb_d      = lb_q;
    if (!run) begin
      pc_d      = RESET_PC;
      if_pc_d   = '0;
      if_inst_d = '0;
      lb_d      = 1'b0;
    end else if (!stall_id) begin
      // Stall holds everything; a branch seen under stall re-resolves next cycle.
      if_pc_d   = pc_q;
      if_inst_d = inst_rom_data_i;
      lb_d      = acc_br;
      pc_d      = acc_br ? {branch_addr[31:2], 2'b00} : pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      if_pc_q   <= '0;
      if_inst_q <= '0;
      lb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      lb_q      <= lb_d;
    end
  end

  assign inst_rom_addr_o = pc_q;
  assign inst_rom_ce_o   = run;
  assign pc_o            = if_pc_q;
  assign inst_o          = if_inst_q;
  assign last_branch_o   = lb_q;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_q, stall_q, flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (perf_clr_i) begin
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (run && !stall_id) fetch_q <= fetch_q + CNT_W'(1);
      if (run && stall_id)  stall_q <= stall_q + CNT_W'(1);
      if (acc_br)           flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign perf_fetch_o = fetch_q;
  assign perf_stall_o = stall_q;
  assign perf_flush_o = flush_q;
`else
  logic unused_perf_clr;

  assign unused_perf_clr = perf_clr_i;
  assign perf_fetch_o    = '0;
  assign perf_stall_o    = '0;
  assign perf_flush_o    = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage against a sequential reference model.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_id = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] inst_rom_data_i;
  logic [31:0] inst_rom_addr_o;
  logic        inst_rom_ce_o;
  logic [31:0] pc_o, inst_o;
  logic        last_branch_o;
  logic        perf_clr_i = 1'b0;
  logic [31:0] perf_fetch_o, perf_stall_o, perf_flush_o;

  if_stage #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .branch(branch),
    .branch_addr(branch_addr), .inst_rom_data_i(inst_rom_data_i),
    .inst_rom_addr_o(inst_rom_addr_o), .inst_rom_ce_o(inst_rom_ce_o),
    .pc_o(pc_o), .inst_o(inst_o), .last_branch_o(last_branch_o),
    .perf_clr_i(perf_clr_i), .perf_fetch_o(perf_fetch_o),
    .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
  );

  always #5 clk = ~clk;

  // ROM contents: word at address A holds A + 0x100.
  assign inst_rom_data_i = inst_rom_addr_o + 32'h100;

  typedef struct {
    logic [31:0] pc, inst, addr, pf, ps, pfl;
    logic        lb, ce;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  bit          m_run;
  logic [31:0] m_pc, m_ifpc, m_ifinst, m_cf, m_cs, m_cfl;
  logic        m_lb;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pc = RESET_PC; m_ifpc = 0; m_ifinst = 0; m_lb = 0;
    m_cf = 0; m_cs = 0; m_cfl = 0;
  endfunction

  // Drive one cycle of inputs, advance the model by one edge, queue the expectation.
  task automatic step(input logic s, input logic b, input logic [31:0] ba, input logic clr);
    exp_t e;
    @(negedge clk);
    stall_id = s; branch = b; branch_addr = ba; perf_clr_i = clr;
    if (!m_run) begin
      m_run = 1; m_ifpc = 0; m_ifinst = 0; m_lb = 0;
    end else if (s) begin
      m_cs++;
    end else begin
      m_cf++;
      m_ifpc   = m_pc;
      m_ifinst = m_pc + 32'h100;
      m_lb     = b;
      if (b) begin
        m_cfl++;
        m_pc = ba & 32'hFFFF_FFFC;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    if (clr) begin m_cf = 0; m_cs = 0; m_cfl = 0; end
    e.pc = m_ifpc; e.inst = m_ifinst; e.addr = m_pc; e.lb = m_lb; e.ce = 1'b1;
`ifdef IF_PERF_CNT_EN
    e.pf = m_cf; e.ps = m_cs; e.pfl = m_cfl;
`else
    e.pf = 0; e.ps = 0; e.pfl = 0;
`endif
    sbq.push_back(e);
  endtask

  task automatic rand_step();
    logic [31:0] ba;
    ba = ($urandom % 8 == 0) ? $urandom : ($urandom % 1024);
    step($urandom % 4 == 0, $urandom % 3 == 0, ba, $urandom % 50 == 0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_pc_o"}, pc_o, 0);
    chk({tag, "_inst_o"}, inst_o, 0);
    chk({tag, "_last_branch"}, {31'b0, last_branch_o}, 0);
    chk({tag, "_rom_addr"}, inst_rom_addr_o, RESET_PC);
    chk({tag, "_rom_ce"}, {31'b0, inst_rom_ce_o}, 0);
    chk({tag, "_perf_fetch"}, perf_fetch_o, 0);
    chk({tag, "_perf_stall"}, perf_stall_o, 0);
    chk({tag, "_perf_flush"}, perf_flush_o, 0);
  endtask

  // Monitor: every edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("inst_o", inst_o, e.inst);
        chk("last_branch", {31'b0, last_branch_o}, {31'b0, e.lb});
        chk("rom_addr", inst_rom_addr_o, e.addr);
        chk("rom_ce", {31'b0, inst_rom_ce_o}, {31'b0, e.ce});
        chk("perf_fetch", perf_fetch_o, e.pf);
        chk("perf_stall", perf_stall_o, e.ps);
        chk("perf_flush", perf_flush_o, e.pfl);
      end
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    chk_reset_vals("por");
    @(posedge clk); #3; rst = 1'b1;

    step(0, 0, 0, 0);              // IDLE -> RUN
    repeat (3) step(0, 0, 0, 0);   // pc_o = 0x08, PC = 0x0C
    step(1, 0, 0, 0);
    step(1, 1, 32'h44, 0);         // branch under stall is ignored
    repeat (2) step(0, 0, 0, 0);   // decode holds 0x10, PC = 0x14
    step(0, 1, 32'h40, 0);
    step(0, 0, 0, 0);
    step(1, 1, 32'h80, 0);
    step(0, 1, 32'h80, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h83, 0);         // unaligned target
    step(0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);              // PC wraps to 0
    step(0, 0, 0, 0);
    step(0, 1, 32'h20, 1);         // clear beats increment
    step(1, 0, 0, 0);

    repeat (300) rand_step();

    // Asynchronous reset mid-cycle during a stall.
    step(1, 0, 0, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(posedge clk); #1;
    chk_reset_vals("arst_hold");
    model_reset();
    #2; rst = 1'b1;

    step(0, 0, 0, 0);
    repeat (60) rand_step();

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    if (sbq.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. Owns the PC, drives the instruction ROM, and feeds the decode stage its `pc_i`, `inst` and `last_branch` inputs. Consumes the decode stage's `branch`, `branch_addr` and `stall_id` outputs, so a taken branch or load-use stall resolved in decode is applied here on the next edge.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `CNT_W`, 32, width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `stall_id`  in  1  load-use stall from decode; hold PC and IF/ID.
- `branch`  in  1  taken branch or jump resolved in decode this cycle.
- `branch_addr`  in  32  target for `branch`.
- `inst_rom_data_i`  in  32  ROM read data; combinational from `inst_rom_addr_o`.
- `inst_rom_addr_o`  out  32  fetch address, equal to the PC register.
- `inst_rom_ce_o`  out  1  ROM enable.
- `pc_o`  out  32  IF/ID PC, to decode `pc_i`.
- `inst_o`  out  32  IF/ID instruction, to decode `inst`.
- `last_branch_o`  out  1  squash flag, to decode `last_branch`.
- `perf_clr_i`  in  1  synchronous clear of the performance counters.
- `perf_fetch_o`, `perf_stall_o`, `perf_flush_o`  out  `CNT_W`  performance counters.

## Operation
- Two-state control FSM:
  - IDLE: reset state. `inst_rom_ce_o`=0. PC held at `RESET_PC`. IF/ID loads zeros.
  - RUN: entered on the first edge after `rst` deasserts. Never left except by reset.
- Accepted branch: `acc_br = RUN & branch & ~stall_id`.
- In RUN, priority per edge:
  - `stall_id`=1: PC, `pc_o`, `inst_o` and `last_branch_o` all hold. `branch` is ignored, because its operands are stale.
  - else `acc_br`:
    - PC ← `{branch_addr[31:2],2'b00}`.
    - IF/ID ← {PC, `inst_rom_data_i`}; this is the wrong-path instruction.
    - `last_branch_o` ← 1, so decode squashes it to a NOP next cycle.
  - else:
    - PC ← PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
    - IF/ID ← {PC, `inst_rom_data_i`}.
    - `last_branch_o` ← 0.
- `inst_rom_addr_o` = PC in all states. `inst_rom_ce_o` = (state==RUN).
- `rst` low at any time: all registers return to reset values immediately, without waiting for the clock. An in-flight branch or stall is discarded.

## Timing
- Reset values: PC=`RESET_PC`, `inst_rom_ce_o`=0, `pc_o`=0, `inst_o`=0, `last_branch_o`=0, all counters 0, state IDLE.
- Fetch latency: an instruction at address A appears on `inst_o` one edge after PC=A with `stall_id`=0.
- Branch cost: one squashed slot.
  - Cycle t: decode holds the branch at B; PC=B+4.
  - Edge t: PC←T, `inst_o`=inst(B+4), `last_branch_o`=1.
  - Edge t+1: `inst_o`=inst(T), `last_branch_o`=0.
- Stall: each cycle with `stall_id`=1 freezes all outputs for exactly that cycle. The stalled instruction re-presents unchanged.
- `branch` and `stall_id` in the same cycle: the stall wins. The branch re-resolves the following cycle.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `perf_fetch_o` increments on each RUN edge with `stall_id`=0.
  - `perf_stall_o` increments on each RUN edge with `stall_id`=1.
  - `perf_flush_o` increments on each `acc_br`.
  - All three wrap modulo 2^`CNT_W`.
  - `perf_clr_i`=1 zeroes all three on the edge, with priority over incrementing.
- `IF_PERF_CNT_EN` undefined:
  - No counter flops are built.
  - The three outputs are constant 0 and `perf_clr_i` is ignored.
  - All other behaviour is identical.

## Test plan
- Reset release, `RESET_PC`=0, ROM[i]=i*4 + 0x100, no stall or branch:
  - First RUN edge gives `pc_o`=0, `inst_o`=0x100, then `pc_o`=4, `inst_o`=0x104.
  - `inst_rom_ce_o` rises one edge after `rst` deasserts.
- Taken branch with decode at B=0x10, `branch_addr`=0x40:
  - Next edge: `inst_o`=inst(0x14) with `last_branch_o`=1.
  - Following edge: `pc_o`=0x40, `inst_o`=inst(0x40), `last_branch_o`=0.
- `stall_id`=1 for 2 cycles with `pc_o`=0x08:
  - `pc_o`, `inst_o` and `inst_rom_addr_o`=0x0C hold for both cycles.
  - `perf_stall_o` advances by 2 when the macro is defined.
- `stall_id`=1 and `branch`=1 with `branch_addr`=0x80 together, then `branch` alone: the branch takes effect only on the second edge, and `perf_flush_o` advances by 1.
- Unaligned `branch_addr`=0x83, and separately PC=0xFFFF_FFFC: PC becomes 0x80 in the first case and wraps to 0x0000_0000 in the second.
- `rst` pulsed low mid-cycle during a stall: outputs go to reset values before the next edge, and the FSM re-enters IDLE.
